// File: rtl/arbitro_escrita_registradores.sv
// Round-robin arbiter for the register bank write port (ALU = req 0, load path = req 1).
// Define ARB_PROTEGE_R0_EN to suppress bank writes to register 0 while keeping the handshake.
module arbitro_escrita_registradores #(
    parameter int unsigned LARGURA_CONT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic                    req0_valid,
    input  logic [4:0]              req0_reg,
    input  logic [31:0]             req0_data,
    output logic                    req0_ready,
    input  logic                    req1_valid,
    input  logic [4:0]              req1_reg,
    input  logic [31:0]             req1_data,
    output logic                    req1_ready,
    output logic                    RegWrite,
    output logic [4:0]              Numero_Reg_Escrita,
    output logic [31:0]             Dado_escrita,
    output logic                    ultimo_grant,
    output logic [LARGURA_CONT-1:0] conflitos
);

    logic        prio_q;
    logic        grant0;
    logic        grant1;
    logic        transfer;
    logic        escreve;
    logic        contencao;
    logic [4:0]  sel_reg;
    logic [31:0] sel_data;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && !stall) begin
            if (req0_valid && req1_valid) begin
                grant0 = ~prio_q;
                grant1 = prio_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign transfer   = grant0 | grant1;
    assign sel_reg    = grant1 ? req1_reg  : req0_reg;
    assign sel_data   = grant1 ? req1_data : req0_data;
    assign contencao  = !rst && !stall && req0_valid && req1_valid;

`ifdef ARB_PROTEGE_R0_EN
    // Handshake still completes for reg 0; only the bank write is dropped.
    assign escreve = transfer && (sel_reg != 5'd0);
`else
    assign escreve = transfer;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite           <= 1'b0;
            Numero_Reg_Escrita <= 5'd0;
            Dado_escrita       <= 32'd0;
            ultimo_grant       <= 1'b0;
            prio_q             <= 1'b0;
            conflitos          <= '0;
        end else begin
            RegWrite <= escreve;
            if (escreve) begin
                Numero_Reg_Escrita <= sel_reg;
                Dado_escrita       <= sel_data;
            end
            if (transfer) begin
                prio_q       <= grant0;
                ultimo_grant <= grant1;
            end
            if (contencao && (conflitos != {LARGURA_CONT{1'b1}})) begin
                conflitos <= conflitos + 1'b1;
            end
        end
    end

endmodule

// File: doc/arbitro_escrita_registradores.md
# arbitro_escrita_registradores

Round-robin arbiter sharing the single write port of the 32×32 MIPS register bank between two writeback requesters: requester 0 is the ALU result path and requester 1 is the load/memory path. Each requester uses a valid/ready handshake. The accepted write is registered and driven onto the bank's `RegWrite` / `Numero_Reg_Escrita` / `Dado_escrita` inputs for exactly one cycle. The block also keeps a saturating contention counter for performance debug.

## Interface
Parameters:
- `LARGURA_CONT`, default 16: width of the contention counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  when high, no request is granted this cycle.
- `req0_valid`  in  1  requester 0 (ALU) has a write pending.
- `req0_reg`  in  5  requester 0 destination register number.
- `req0_data`  in  32  requester 0 write data.
- `req0_ready`  out  1  requester 0 is granted this cycle.
- `req1_valid`, `req1_reg`, `req1_data`, `req1_ready`: same as requester 0, for requester 1 (load path).
- `RegWrite`  out  1  registered write enable to the register bank.
- `Numero_Reg_Escrita`  out  5  registered destination register to the bank.
- `Dado_escrita`  out  32  registered write data to the bank.
- `ultimo_grant`  out  1  index of the most recently granted requester.
- `conflitos`  out  `LARGURA_CONT`  saturating count of cycles with both valids high and `stall` low.

## Operation
- **Priority pointer.** One bit, `prio`, names the favoured requester.
- **Grant rule** (combinational, evaluated only when `rst`=0 and `stall`=0):
  - Only one valid high: that requester is granted, regardless of `prio`.
  - Both valid high: requester `prio` is granted.
  - No valid high: no grant.
- **Ready.** `reqN_ready` is high exactly when requester N is granted. At most one ready is high per cycle.
- **Transfer.** A transfer occurs at a rising edge where `reqN_valid`=1 and `reqN_ready`=1. On transfer:
  - `Numero_Reg_Escrita` ← `reqN_reg`; `Dado_escrita` ← `reqN_data`; `RegWrite` ← 1.
  - `prio` ← ~N; `ultimo_grant` ← N.
- **No transfer.** `RegWrite` ← 0. `Numero_Reg_Escrita` and `Dado_escrita` hold their previous values. `prio` and `ultimo_grant` are unchanged.
- **Loser of an arbitration.** Keeps `valid` high with stable `reg`/`data`. It is granted the next non-stalled cycle, because `prio` has flipped. Starvation-free: the maximum wait is one granted cycle of the other requester.
- **Same destination register.** Both requesters targeting the same register is not special-cased. The writes land in grant order, so the later write wins in the bank.
- **Contention counter.** `conflitos` increments by 1 on every non-stalled, non-reset cycle with both valids high. It saturates at all-ones and never wraps.
- **Requester obligations** (assertion-checked by the bench): a requester must not drop `valid` or change `reg`/`data` while valid and not ready.

## Timing
- **Reset values** (at the first rising edge with `rst`=1): `RegWrite`=0, `Numero_Reg_Escrita`=0, `Dado_escrita`=0, `ultimo_grant`=0, `prio`=0 (requester 0 favoured), `conflitos`=0.
- Both readies are forced low while `rst`=1.
- **Reset mid-operation.** A request pending during reset is not accepted and not counted. `RegWrite` is 0 on the cycle after reset.
- **Ready latency.** `reqN_ready` is combinational from valids, `prio`, `stall` and `rst`: zero cycles.
- **Write latency.**
  - Request accepted at edge T.
  - `RegWrite`=1 during cycle T+1.
  - The bank stores the value at edge T+1.
  - A combinational bank read of that register shows the new value after edge T+1, two edges after acceptance.
- **Throughput.** One write per cycle. Back-to-back grants alternate when both requesters are continuously valid.
- **Stall.** `stall`=1 forces both readies low. `RegWrite` is 0 in the following cycle. `prio` and the counter are unchanged.

## Configuration
- **`ARB_PROTEGE_R0_EN` defined:**
  - A granted request with `reg`=0 completes its handshake normally (ready high, `prio` flips, `ultimo_grant` updates).
  - `RegWrite` is forced to 0 for that transfer and `Numero_Reg_Escrita`/`Dado_escrita` hold their values, so register 0 is never written.
- **Not defined:** writes to register 0 pass to the bank like any other register.

## Test plan
- **Reset.** Assert `rst` for 2 cycles with both valids high. Response: both readies 0, `RegWrite`=0, `conflitos`=0, `ultimo_grant`=0.
- **Single requester.** Only req1 valid with reg=7, data=0x0000_00AA. Response: `req1_ready`=1 the same cycle; next cycle `RegWrite`=1, `Numero_Reg_Escrita`=7, `Dado_escrita`=0xAA; `ultimo_grant`=1.
- **Contention alternation.** Both valid for 4 cycles after reset, req0 reg=3 data=0x11 and req1 reg=4 data=0x22. Response: grants in order 0,1,0,1; `RegWrite` high for 4 consecutive cycles; `conflitos`=4.
- **Stall.** Both valid with `stall`=1 for 3 cycles, then `stall`=0. Response: no ready during the stall, `RegWrite`=0 and `conflitos` unchanged during the stall; then req0 granted first if `prio`=0.
- **Counter saturation.** Set `LARGURA_CONT`=2 and hold contention for 6 cycles. Response: `conflitos` reaches 3 and stays at 3.
- **Register-0 write.** req0 writes reg=0, data=0x55. With `ARB_PROTEGE_R0_EN` defined: ready=1, `RegWrite` stays 0, `ultimo_grant`=0. Without the macro: `RegWrite`=1 with `Numero_Reg_Escrita`=0.
